// File: rtl/saed32_fifo_pkg.sv
// Shared sizing for the 32x32 SRAM-backed FIFO controller and its output buffer.
package saed32_fifo_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int OBUF_DEPTH = 2;
  localparam int COUNT_W    = 6;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [COUNT_W-1:0]    count_t;
endpackage

// File: rtl/saed32_fifo_obuf.sv
// 2-entry output buffer behind the SRAM read port; head is always slot 0, written
// data is visible one cycle later, and the head holds steady while the consumer stalls.
module saed32_fifo_obuf
  import saed32_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       wr_vld,
  input  word_t      wr_dat,
  input  logic       rd_rdy,
  output word_t      head_dat,
  output logic [1:0] buf_cnt,
  output logic       rd_vld,
  output logic       pop
);
  word_t      ent0_q, ent0_d;
  word_t      ent1_q, ent1_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] slot;

  assign rd_vld   = (cnt_q != 2'd0);
  assign pop      = rd_vld & rd_rdy;
  assign head_dat = ent0_q;
  assign buf_cnt  = cnt_q;
  assign slot     = cnt_q - {1'b0, pop};

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = 2'd0;
    end else begin
      if (pop) ent0_d = ent1_q;
      // The write lands after the shift so a pop+write at occupancy 1 refills slot 0.
      if (wr_vld) begin
        if (slot == 2'd0) ent0_d = wr_dat;
        else              ent1_d = wr_dat;
      end
      cnt_d = cnt_q + {1'b0, wr_vld} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/saed32_fifo32x32_ctrl.sv
// FIFO controller over a 1-cycle-latency dual-port SRAM: push to out_valid is 3 cycles
// when empty, one word per clock sustained; in_ready drops only when the SRAM holds 32 unissued words.
module saed32_fifo32x32_ctrl
  import saed32_fifo_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [COUNT_W-1:0]    count,
  output logic [ADDR_WIDTH-1:0] mem_A0,
  output logic [DATA_WIDTH-1:0] mem_D0,
  output logic [DATA_WIDTH-1:0] mem_WEM0,
  output logic                  mem_WE0,
  output logic                  mem_CE0,
  output logic [ADDR_WIDTH-1:0] mem_A1,
  output logic [DATA_WIDTH-1:0] mem_D1,
  output logic [DATA_WIDTH-1:0] mem_WEM1,
  output logic                  mem_WE1,
  output logic                  mem_CE1,
  input  logic [DATA_WIDTH-1:0] mem_Q1
);
  addr_t      wptr_q, wptr_d;
  addr_t      rptr_q, rptr_d;
  count_t     mem_cnt_q, mem_cnt_d;
  logic       inflight_q, inflight_d;
  logic       push, issue, pop;
  logic [1:0] buf_cnt;
  logic [2:0] occ_after;

  assign in_ready  = (mem_cnt_q < COUNT_W'(DEPTH)) & ~clr;
  assign push      = in_valid & in_ready;
  // Buffer slots still committed after this cycle's pop; a new read needs one free.
  assign occ_after = {1'b0, buf_cnt} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue     = (mem_cnt_q != '0) & (occ_after < 3'd2) & ~clr;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    mem_cnt_d  = mem_cnt_q;
    inflight_d = inflight_q;
    if (clr) begin
      wptr_d     = '0;
      rptr_d     = '0;
      mem_cnt_d  = '0;
      inflight_d = 1'b0;
    end else begin
      if (push)  wptr_d = wptr_q + 1'b1;
      if (issue) rptr_d = rptr_q + 1'b1;
      mem_cnt_d  = mem_cnt_q + COUNT_W'(push) - COUNT_W'(issue);
      inflight_d = issue;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_cnt_q  <= mem_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  assign mem_CE0  = push;
  assign mem_WE0  = push;
  assign mem_A0   = push ? wptr_q : '0;
  assign mem_D0   = push ? in_data : '0;
  assign mem_WEM0 = {DATA_WIDTH{push}};

  assign mem_CE1  = issue;
  assign mem_WE1  = 1'b0;
  assign mem_A1   = issue ? rptr_q : '0;
  assign mem_D1   = '0;
  assign mem_WEM1 = '0;

  assign count = mem_cnt_q + COUNT_W'(inflight_q) + COUNT_W'(buf_cnt);

  saed32_fifo_obuf u_obuf (
    .clk      (CLK),
    .rst      (RST),
    .clr      (clr),
    .wr_vld   (inflight_q),
    .wr_dat   (mem_Q1),
    .rd_rdy   (out_ready),
    .head_dat (out_data),
    .buf_cnt  (buf_cnt),
    .rd_vld   (out_valid),
    .pop      (pop)
  );
endmodule

// File: tb/tb_saed32_fifo32x32_ctrl.sv
// Directed bench for the SRAM FIFO controller with a behavioural 1-cycle-latency SRAM.
module tb_saed32_fifo32x32_ctrl;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [5:0]  count;
  logic [4:0]  mem_A0, mem_A1;
  logic [31:0] mem_D0, mem_WEM0, mem_D1, mem_WEM1;
  logic        mem_WE0, mem_CE0, mem_WE1, mem_CE1;
  logic [31:0] mem_Q1 = '0;

  logic [31:0] sram [32];
  logic [4:0]  wexp;
  int n_cmp = 0;
  int n_mis = 0;

  always #5 CLK = ~CLK;

  saed32_fifo32x32_ctrl dut (
    .CLK(CLK), .RST(RST), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .mem_A0(mem_A0), .mem_D0(mem_D0), .mem_WEM0(mem_WEM0), .mem_WE0(mem_WE0), .mem_CE0(mem_CE0),
    .mem_A1(mem_A1), .mem_D1(mem_D1), .mem_WEM1(mem_WEM1), .mem_WE1(mem_WE1), .mem_CE1(mem_CE1),
    .mem_Q1(mem_Q1)
  );

  always @(posedge CLK) begin
    if (mem_CE0 && mem_WE0) sram[mem_A0] <= (sram[mem_A0] & ~mem_WEM0) | (mem_D0 & mem_WEM0);
    if (mem_CE1 && !mem_WE1) mem_Q1 <= sram[mem_A1];
  end

  // Expected write pointer, advanced on every accepted push.
  always @(posedge CLK or posedge RST) begin
    if (RST)                        wexp <= '0;
    else if (clr)                   wexp <= '0;
    else if (in_valid && in_ready)  wexp <= wexp + 5'd1;
  end

  task automatic test_reset();
    #2 RST = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_mis++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    n_cmp++; if (count !== 6'd0) begin n_mis++; $display("FAIL rst_count: got %0d want 0", count); end
    n_cmp++;
    if ({mem_CE0, mem_WE0, mem_CE1, mem_WE1, mem_A0, mem_A1} !== 14'h0 ||
        (mem_D0 | mem_D1 | mem_WEM0 | mem_WEM1) !== 32'h0) begin
      n_mis++; $display("FAIL rst_mem_ports: got ce0=%b ce1=%b a0=%0d a1=%0d wem0=%h want all 0",
                        mem_CE0, mem_CE1, mem_A0, mem_A1, mem_WEM0);
    end
    @(negedge CLK) RST = 1'b0;
    @(negedge CLK);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    @(negedge CLK); in_valid = 1'b1; in_data = 32'hDEADBEEF; #1;
    n_cmp++;
    if ({mem_CE0, mem_WE0} !== 2'b11 || mem_A0 !== 5'd0 || mem_D0 !== 32'hDEADBEEF || mem_WEM0 !== 32'hFFFFFFFF) begin
      n_mis++; $display("FAIL single_write: got ce0=%b we0=%b a0=%0d d0=%h wem0=%h want 1 1 0 deadbeef ffffffff",
                        mem_CE0, mem_WE0, mem_A0, mem_D0, mem_WEM0);
    end
    @(negedge CLK); in_valid = 1'b0; #1;
    n_cmp++;
    if (mem_CE1 !== 1'b1 || mem_WE1 !== 1'b0 || mem_A1 !== 5'd0) begin
      n_mis++; $display("FAIL single_issue: got ce1=%b we1=%b a1=%0d want 1 0 0", mem_CE1, mem_WE1, mem_A1);
    end
    @(negedge CLK); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
    @(negedge CLK); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || count !== 6'd1) begin
      n_mis++; $display("FAIL single_deliver: got v=%b d=%h cnt=%0d want 1 deadbeef 1", out_valid, out_data, count);
    end
    out_ready = 1'b1;
    @(negedge CLK); out_ready = 1'b0; #1;
    n_cmp++;
    if (out_valid !== 1'b0 || count !== 6'd0) begin
      n_mis++; $display("FAIL single_pop: got v=%b cnt=%0d want 0 0", out_valid, count);
    end
  endtask

  task automatic test_fill();
    int acc = 0;
    int got = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK); in_valid = 1'b1; in_data = 32'(acc); #1;
      if (in_ready) acc++;
    end
    @(negedge CLK); in_valid = 1'b0; #1;
    n_cmp++; if (acc != 34) begin n_mis++; $display("FAIL fill_accepted: got %0d want 34", acc); end
    n_cmp++; if (count !== 6'd34) begin n_mis++; $display("FAIL fill_count: got %0d want 34", count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (c == 1) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL fill_ready_return: got %b want 1", in_ready); end
      end
      if (out_valid) begin
        n_cmp++; if (out_data !== 32'(got)) begin n_mis++; $display("FAIL fill_order: got %h want %h", out_data, 32'(got)); end
        got++;
      end
      @(negedge CLK); #1;
    end
    out_ready = 1'b0;
    n_cmp++; if (got != 34) begin n_mis++; $display("FAIL fill_drained: got %0d want 34", got); end
    n_cmp++; if (count !== 6'd0) begin n_mis++; $display("FAIL fill_empty: got %0d want 0", count); end
  endtask

  task automatic test_stream();
    int acc = 0, got = 0, first = -1, last = -1, wraps = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 130; c++) begin
      @(negedge CLK); in_valid = (acc < 100); in_data = 32'h100 + 32'(acc); #1;
      if (in_valid && in_ready) begin
        n_cmp++; if (mem_A0 !== wexp) begin n_mis++; $display("FAIL stream_waddr: got %0d want %0d", mem_A0, wexp); end
        if (mem_A0 == 5'd31) wraps++;
        acc++;
      end
      if (out_valid) begin
        n_cmp++;
        if (out_data !== 32'h100 + 32'(got)) begin n_mis++; $display("FAIL stream_order: got %h want %h", out_data, 32'h100 + 32'(got)); end
        if (first < 0) first = c;
        last = c;
        got++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (got != 100) begin n_mis++; $display("FAIL stream_total: got %0d want 100", got); end
    n_cmp++; if (last - first != 99) begin n_mis++; $display("FAIL stream_rate: got span %0d want 99", last - first); end
    n_cmp++; if (first != 3) begin n_mis++; $display("FAIL stream_latency: got %0d want 3", first); end
    n_cmp++; if (wraps != 3) begin n_mis++; $display("FAIL stream_wraps: got %0d want 3", wraps); end
  endtask

  task automatic test_backpressure();
    int acc = 0, got = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_dat = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      in_valid = (acc < 60); in_data = 32'h5000 + 32'(acc);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== prev_dat) begin
          n_mis++; $display("FAIL bp_stable: got v=%b d=%h want 1 %h", out_valid, out_data, prev_dat);
        end
      end
      if (in_valid && in_ready) acc++;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_data !== 32'h5000 + 32'(got)) begin n_mis++; $display("FAIL bp_order: got %h want %h", out_data, 32'h5000 + 32'(got)); end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_dat = out_data;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge CLK); #1;
    n_cmp++; if (got != 60 || acc != 60) begin n_mis++; $display("FAIL bp_total: got pushed=%0d popped=%0d want 60 60", acc, got); end
    n_cmp++; if (count !== 6'd0) begin n_mis++; $display("FAIL bp_empty: got %0d want 0", count); end
  endtask

  task automatic test_flush();
    @(negedge CLK); in_valid = 1'b1; in_data = 32'hAAAA0000;
    @(negedge CLK); in_data = 32'hBBBB0000;
    @(negedge CLK); in_valid = 1'b0;
    @(negedge CLK); clr = 1'b1; out_ready = 1'b1; #1;
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || mem_CE1 !== 1'b0) begin
      n_mis++; $display("FAIL flush_cycle: got v=%b rdy=%b ce1=%b want 1 0 0", out_valid, in_ready, mem_CE1);
    end
    @(negedge CLK); clr = 1'b0; out_ready = 1'b0; #1;
    n_cmp++;
    if (count !== 6'd0 || out_valid !== 1'b0) begin
      n_mis++; $display("FAIL flush_after: got cnt=%0d v=%b want 0 0", count, out_valid);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL flush_ghost: got v=%b d=%h want 0", out_valid, out_data); end
    end
    @(negedge CLK); in_valid = 1'b1; in_data = 32'h1; #1;
    n_cmp++; if (mem_CE0 !== 1'b1 || mem_A0 !== 5'd0) begin n_mis++; $display("FAIL flush_waddr: got ce0=%b a0=%0d want 1 0", mem_CE0, mem_A0); end
    @(negedge CLK); in_valid = 1'b0; #1;
    n_cmp++; if (mem_CE1 !== 1'b1 || mem_A1 !== 5'd0) begin n_mis++; $display("FAIL flush_raddr: got ce1=%b a1=%0d want 1 0", mem_CE1, mem_A1); end
    @(negedge CLK);
    @(negedge CLK); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h1) begin n_mis++; $display("FAIL flush_deliver: got v=%b d=%h want 1 1", out_valid, out_data); end
    out_ready = 1'b1;
    @(negedge CLK); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); in_valid = 1'b1; in_data = 32'h77 + 32'(i);
    end
    @(negedge CLK); in_valid = 1'b0; RST = 1'b1; #1;
    n_cmp++;
    if (count !== 6'd0 || out_valid !== 1'b0 || out_data !== 32'h0 || {mem_CE0, mem_CE1, mem_A0, mem_A1} !== 12'h0) begin
      n_mis++; $display("FAIL midrst_outputs: got cnt=%0d v=%b d=%h ce0=%b ce1=%b want all 0",
                        count, out_valid, out_data, mem_CE0, mem_CE1);
    end
    @(negedge CLK) RST = 1'b0;
    @(negedge CLK); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || count !== 6'd0 || out_valid !== 1'b0) begin
      n_mis++; $display("FAIL midrst_release: got rdy=%b cnt=%0d v=%b want 1 0 0", in_ready, count, out_valid);
    end
    in_valid = 1'b1; in_data = 32'h9; #1;
    n_cmp++; if (mem_A0 !== 5'd0) begin n_mis++; $display("FAIL midrst_waddr: got %0d want 0", mem_A0); end
    @(negedge CLK); in_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h9) begin n_mis++; $display("FAIL midrst_deliver: got v=%b d=%h want 1 9", out_valid, out_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/saed32_fifo32x32_ctrl.md
# saed32_fifo32x32_ctrl

Synchronous FIFO controller that sits directly upstream of the `wrap_saed32_32x32` dual-port SRAM wrapper and turns it into a 32-entry, 32-bit FIFO with valid/ready handshakes. Port 0 is the write port and port 1 is the read port. Read data passes through a 2-entry output buffer, so the FIFO sustains one push and one pop per clock.

## Interface
- `DATA_WIDTH`, 32: word width; fixed by the macro.
- `ADDR_WIDTH`, 5: SRAM address width; memory depth is 2**ADDR_WIDTH = 32.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, asynchronous and active-high.
- `clr` in 1: synchronous flush, active-high.
- `in_valid` in 1 / `in_ready` out 1 / `in_data` in 32: push handshake.
- `out_valid` out 1 / `out_ready` in 1 / `out_data` out 32: pop handshake.
- `count` out 6: total occupancy, 0..34 (memory + in-flight + buffer).
- `mem_A0` out 5, `mem_D0` out 32, `mem_WEM0` out 32, `mem_WE0` out 1, `mem_CE0` out 1: SRAM port 0.
- `mem_A1` out 5, `mem_D1` out 32, `mem_WEM1` out 32, `mem_WE1` out 1, `mem_CE1` out 1: SRAM port 1.
- `mem_Q1` in 32: SRAM port 1 read data.

## Operation
- **Write path:**
  - Push is accepted when `in_valid & in_ready`.
  - `in_ready = (mem_count < 32) & ~clr`.
  - An accepted push drives `mem_CE0=1`, `mem_WE0=1`, `mem_A0=wptr`, `mem_D0=in_data` and `mem_WEM0=all ones` in the same cycle.
  - `wptr` increments modulo 32.
- **Read issue:**
  - A read is issued when `mem_count > 0 & (buf_cnt + inflight - pop) < 2 & ~clr`, where `pop = out_valid & out_ready`.
  - A read drives `mem_CE1=1`, `mem_WE1=0`, `mem_A1=rptr`.
  - `rptr` increments modulo 32 and `inflight` is set for the next cycle.
- **Port 1 idle values:** `mem_D1=0` and `mem_WEM1=0` at all times.
- **Port 0 idle values:** when not writing, `mem_CE0=0` and `mem_WE0=0`.
- **Memory count:** `mem_count` counts written but not yet issued entries, range 0..32. It changes by +push and -issue in the same cycle, so a simultaneous push and issue leaves it unchanged.
- **Capture:** when `inflight=1`, `mem_Q1` is written into the output buffer that cycle.
- **Output buffer:** 2-entry FIFO. `out_data` is the head entry and `out_valid = buf_cnt != 0`.
- **Ordering:** a read is never issued to a slot in the same cycle that slot is written. `mem_count` only covers writes from prior cycles, so no same-address collision occurs.
- **`clr`:**
  - Pointers, `mem_count`, `buf_cnt` and `inflight` go to 0 at the next edge.
  - Any read in flight is discarded.
  - `out_valid` stays as-is during the `clr` cycle, but a pop in that cycle is a no-op on the data.
- **Reset values:** all pointers and counters are 0. `out_valid=0`, `count=0`, `out_data=0`. All mem_* outputs are 0. `in_ready=1` from the first cycle after reset deassertion.
- **Reset mid-operation:** all contents are lost. The SRAM contents are not cleared.

## Timing
- **Latency, empty FIFO:** push accepted in cycle t → read issued in t+1 → `mem_Q1` valid in t+2 and captured → `out_valid=1` in t+3.
- **Throughput:** with continuous `in_valid` and `out_ready`, one word per clock once the pipe has filled.
- **Full:** `in_ready=0` when `mem_count=32`. A pop in that cycle frees a slot only after the resulting read issue, so `in_ready` returns one cycle after the issue.
- **Wrap-around:** pointers roll 31→0 with no bubble.
- **Backpressure:** `out_data` and `out_valid` stay stable while `out_valid & ~out_ready`.
- **Combinational paths:** `in_ready` depends on registers and `clr` only. The read-issue decision depends combinationally on `out_ready`.

## Structure
- **Package `saed32_fifo_pkg`:** `DATA_WIDTH`, `ADDR_WIDTH`, `DEPTH=32`, `OBUF_DEPTH=2`, and `COUNT_W=6`.
- **Sub-module `saed32_fifo_obuf`:** 2-entry output buffer. Inputs: write strobe and data. Outputs: head data, `buf_cnt`, and pop.
- **Top level:** pointers, `mem_count`, `inflight`, and SRAM port drive.

## Test plan
- **Reset:** assert `RST` mid-traffic → all outputs 0, `in_ready=1` one cycle later, and `count=0`.
- **Single word:** push 0xDEADBEEF into an empty FIFO at cycle t → `mem_CE0=1`, `mem_A0=0` at t; `mem_CE1=1`, `mem_A1=0` at t+1; `out_valid=1`, `out_data=0xDEADBEEF` at t+3.
- **Fill:** push 40 words with `out_ready=0` → 34 words accepted, `in_ready=0` while `mem_count=32`, and `count=34`. Then drain → values come out in order 0..33.
- **Streaming:** push and pop continuously for 100 words → one word per clock in steady state, pointers wrap 31→0 three times, and order is preserved.
- **Random backpressure:** toggle `out_ready` randomly with 50% probability → no loss, no duplication, and `out_data` stable during stalls.
- **Flush with read in flight:** assert `clr` while a read is in flight → `count=0` and `out_valid=0` next cycle, and the in-flight word never appears. A subsequent push of 0x1 reads from address 0 and is delivered.
